instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder/loader for the simple CPU. It accepts decoded instruction fields (opcode, two source register addresses, one destination register address) over a valid/ready handshake. It packs each set of fields into the 16-bit instruction format and writes the words sequentially into instruction memory from address 0. It is the write-side counterpart of the instruction decoder and is used to load programs before the CPU runs.

## Interface

Parameters:
- ADDR_W, default 4, instruction memory address width (capacity 2^ADDR_W words).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  one-cycle request to begin a program load; honoured only in IDLE.
- i_valid  input  1  field inputs valid this cycle.
- o_ready  output  1  encoder accepts fields this cycle; high only in LOAD.
- i_opcode  input  4  opcode field.
- i_srcadd1  input  4  source register 1 address.
- i_srcadd2  input  4  source register 2 address.
- i_destadd  input  4  destination register address.
- i_last  input  1  qualifies the accepted beat as the final instruction of the program.
- o_mem_we  output  1  instruction memory write enable, one cycle per accepted beat.
- o_mem_addr  output  ADDR_W  instruction memory write address.
- o_mem_wdata  output  16  encoded instruction word.
- o_busy  output  1  high in LOAD and DONE.
- o_done  output  1  one-cycle pulse when a load completes.
- o_count  output  ADDR_W+1  number of words written in the current/last load.
- o_full  output  1  sticky; the load ended because memory capacity was reached without i_last.

## Operation

- Encoding: o_mem_wdata = {i_opcode, i_srcadd1, i_srcadd2, i_destadd}, so bits [15:12]=opcode, [11:8]=src1, [7:4]=src2, [3:0]=dest. No field checking is performed; every 4-bit value passes through unchanged.
- FSM states:
  - IDLE → LOAD on i_start. Entering LOAD clears the write pointer, o_count and o_full.
  - LOAD → DONE on an accepted beat (i_valid & o_ready) when either i_last=1 or the write pointer equals 2^ADDR_W−1.
  - DONE → IDLE unconditionally after one cycle.
- In LOAD, o_ready = 1. An accepted beat:
  - registers the encoded word and the current pointer onto o_mem_wdata/o_mem_addr;
  - asserts o_mem_we for exactly one cycle;
  - increments the pointer and o_count.
- In LOAD with i_valid=0, the pointer, o_count and the memory outputs hold, and o_mem_we=0.
- Capacity: a beat accepted at pointer 2^ADDR_W−1 is written. If that beat has i_last=0, o_full is set. The pointer never wraps to 0 within a load.
- If the final beat has i_last=1 and lands exactly at the last address, o_full stays 0.
- i_start is ignored in LOAD and DONE. i_last is ignored unless the beat is accepted.
- o_count and o_full hold their values through IDLE until the next i_start.
- Reset (at any time, including mid-load):
  - state IDLE; o_ready, o_mem_we, o_busy, o_done, o_full = 0; o_mem_addr, o_mem_wdata, o_count = 0.
  - Memory words already written are not erased.

## Timing

- Beat accepted at edge N: o_mem_we=1 with its address/data during cycle N+1 (1-cycle latency). Back-to-back beats produce back-to-back writes.
- i_start sampled at edge N: o_ready=1 from cycle N+1.
- Final beat accepted at edge N: state DONE, o_ready=0, o_done=1, o_mem_we=1 (final write), o_count final, all in cycle N+1. IDLE and o_busy=0 from cycle N+2.
- i_start in the DONE cycle is dropped. i_start in the first IDLE cycle after DONE starts a new load.
- All outputs are registered except o_ready and o_busy, which are decoded directly from the state register.

## Test plan

- Reset/idle: assert i_rst mid-cycle → all outputs 0 immediately. With i_valid=1 and no i_start, no o_mem_we ever fires.
- Single beat: i_start, then fields (0x3, 0x1, 0x2, 0x4) with i_last=1 → next cycle o_mem_we=1, addr 0, wdata 0x3124, o_done=1, o_count=1. IDLE the cycle after.
- Stalled stream: 3 beats (0xA5F0, 0x1234, 0xFFFF with i_last on the third) with idle gaps of 0/2/1 cycles → writes at addrs 0,1,2 with exact words, o_mem_we high exactly 3 cycles, o_count=3, o_full=0.
- Capacity, ADDR_W=4: 16 beats with i_last=0 → addrs 0..15, DONE after the 16th, o_full=1, o_count=16, o_ready low afterwards. Repeat with i_last on the 16th beat → o_full=0.
- Ignored start: pulse i_start during LOAD and during DONE → pointer not reset, no new load. A second i_start after IDLE → write restarts at addr 0, o_count and o_full cleared.
- Reset mid-load: after 5 writes, pulse i_rst → IDLE with o_count=0. A new load starts at addr 0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Handshake and memory-write bundle for the instruction encoder.
// master drives the fields, slave is the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 4
);
    logic              i_start;
    logic              i_valid;
    logic              o_ready;
    logic [3:0]        i_opcode;
    logic [3:0]        i_srcadd1;
    logic [3:0]        i_srcadd2;
    logic [3:0]        i_destadd;
    logic              i_last;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [15:0]       o_mem_wdata;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W:0]   o_count;
    logic              o_full;

    modport master (
        output i_start, i_valid, i_opcode, i_srcadd1,
        output i_srcadd2, i_destadd, i_last,
        input  o_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_busy, o_done, o_count, o_full
    );

    modport slave (
        input  i_start, i_valid, i_opcode, i_srcadd1,
        input  i_srcadd2, i_destadd, i_last,
        output o_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_busy, o_done, o_count, o_full
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 16-bit words and writes them
// sequentially into instruction memory from address 0.
module instr_encoder #(
    parameter int ADDR_W = 4
) (
    input logic            i_clk,
    input logic            i_rst,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_PTR =
        (ADDR_W+1)'((1 << ADDR_W) - 1);

    state_t state;
    logic   accept;
    logic   at_end;

    assign bus.o_ready = (state == LOAD);
    assign bus.o_busy  = (state != IDLE);
    assign accept      = bus.i_valid & bus.o_ready;
    // o_count doubles as the write pointer; it never exceeds LAST_PTR in LOAD
    assign at_end      = (bus.o_count == LAST_PTR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            bus.o_done      <= 1'b0;
            bus.o_count     <= '0;
            bus.o_full      <= 1'b0;
        end else begin
            bus.o_mem_we <= 1'b0;
            bus.o_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state       <= LOAD;
                        bus.o_count <= '0;
                        bus.o_full  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        bus.o_mem_we    <= 1'b1;
                        bus.o_mem_addr  <= bus.o_count[ADDR_W-1:0];
                        bus.o_mem_wdata <= {bus.i_opcode, bus.i_srcadd1,
                                            bus.i_srcadd2, bus.i_destadd};
                        bus.o_count     <= bus.o_count + 1'b1;
                        if (bus.i_last || at_end) begin
                            state      <= DONE;
                            bus.o_done <= 1'b1;
                            bus.o_full <= at_end & ~bus.i_last;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a write scoreboard.
// Expected writes are queued when beats are driven, checked on o_mem_we.
module tb_instr_encoder;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   we_cnt;
    logic [ADDR_W:0] exp_ptr;
    logic [ADDR_W+15:0] q[$];

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [ADDR_W+15:0] e;
        if (bus.o_mem_we === 1'b1) begin
            we_cnt++;
            if (q.size() == 0) begin
                chk("spurious_we", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("mem_addr", 32'(bus.o_mem_addr), 32'(e[ADDR_W+15:16]));
                chk("mem_wdata", 32'(bus.o_mem_wdata), 32'(e[15:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.i_start = 1'b1;
        exp_ptr = '0;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] op, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [3:0] d,
                        input logic last);
        bus.i_valid   = 1'b1;
        bus.i_opcode  = op;
        bus.i_srcadd1 = s1;
        bus.i_srcadd2 = s2;
        bus.i_destadd = d;
        bus.i_last    = last;
        chk("ready_at_beat", 32'(bus.o_ready), 32'd1);
        q.push_back({exp_ptr[ADDR_W-1:0], op, s1, s2, d});
        exp_ptr = exp_ptr + 1'b1;
        step();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        we_cnt = 0;
        exp_ptr = '0;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_opcode = '0;
        bus.i_srcadd1 = '0;
        bus.i_srcadd2 = '0;
        bus.i_destadd = '0;
        bus.i_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ready", 32'(bus.o_ready), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_we", 32'(bus.o_mem_we), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_full", 32'(bus.o_full), 32'd0);
        chk("rst_count", 32'(bus.o_count), 32'd0);
        chk("rst_addr", 32'(bus.o_mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.o_mem_wdata), 32'd0);

        // valid without start must never write
        bus.i_valid = 1'b1;
        bus.i_opcode = 4'h7;
        repeat (4) step();
        bus.i_valid = 1'b0;
        chk("nostart_we_cnt", 32'(we_cnt), 32'd0);
        chk("nostart_count", 32'(bus.o_count), 32'd0);

        // asynchronous reset mid-cycle while a write is presented
        start_load();
        beat(4'h9, 4'h8, 4'h7, 4'h6, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(bus.o_mem_we), 32'd0);
        chk("arst_count", 32'(bus.o_count), 32'd0);
        chk("arst_wdata", 32'(bus.o_mem_wdata), 32'd0);
        chk("arst_ready", 32'(bus.o_ready), 32'd0);
        chk("arst_busy", 32'(bus.o_busy), 32'd0);
        q.delete();
        step();
        rst = 1'b0;
        step();

        // single beat
        start_load();
        chk("single_ready", 32'(bus.o_ready), 32'd1);
        chk("single_busy", 32'(bus.o_busy), 32'd1);
        beat(4'h3, 4'h1, 4'h2, 4'h4, 1'b1);
        chk("single_we", 32'(bus.o_mem_we), 32'd1);
        chk("single_wdata", 32'(bus.o_mem_wdata), 32'h3124);
        chk("single_done", 32'(bus.o_done), 32'd1);
        chk("single_count", 32'(bus.o_count), 32'd1);
        chk("single_ready_done", 32'(bus.o_ready), 32'd0);
        step();
        chk("single_idle_busy", 32'(bus.o_busy), 32'd0);
        chk("single_idle_done", 32'(bus.o_done), 32'd0);

        // stalled stream
        we_cnt = 0;
        start_load();
        beat(4'hA, 4'h5, 4'hF, 4'h0, 1'b0);
        step();
        chk("stall_we_gap", 32'(bus.o_mem_we), 32'd0);
        chk("stall_count_hold", 32'(bus.o_count), 32'd1);
        chk("stall_addr_hold", 32'(bus.o_mem_addr), 32'd0);
        step();
        beat(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        step();
        beat(4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
        chk("stall_count", 32'(bus.o_count), 32'd3);
        chk("stall_full", 32'(bus.o_full), 32'd0);
        chk("stall_done", 32'(bus.o_done), 32'd1);
        step();
        chk("stall_we_cnt", 32'(we_cnt), 32'd3);

        // capacity with i_last exactly on the last address
        start_load();
        for (int i = 0; i < 16; i++) begin
            beat(4'(i), 4'(15 - i), 4'(i * 3), 4'(i + 5), i == 15);
        end
        chk("caplast_done", 32'(bus.o_done), 32'd1);
        chk("caplast_count", 32'(bus.o_count), 32'd16);
        chk("caplast_full", 32'(bus.o_full), 32'd0);
        step();

        // capacity without i_last
        start_load();
        for (int i = 0; i < 16; i++) begin
            beat(4'(i * 7), 4'(i), 4'(~i), 4'(i + 1), 1'b0);
        end
        chk("cap_done", 32'(bus.o_done), 32'd1);
        chk("cap_ready", 32'(bus.o_ready), 32'd0);
        chk("cap_count", 32'(bus.o_count), 32'd16);
        chk("cap_full", 32'(bus.o_full), 32'd1);
        chk("cap_addr", 32'(bus.o_mem_addr), 32'd15);
        bus.i_valid = 1'b1;
        step();
        step();
        bus.i_valid = 1'b0;
        chk("cap_idle_ready", 32'(bus.o_ready), 32'd0);
        chk("cap_hold_full", 32'(bus.o_full), 32'd1);
        chk("cap_hold_count", 32'(bus.o_count), 32'd16);

        // starts in LOAD and DONE are ignored
        start_load();
        chk("restart_full", 32'(bus.o_full), 32'd0);
        chk("restart_count", 32'(bus.o_count), 32'd0);
        beat(4'h1, 4'h1, 4'h1, 4'h1, 1'b0);
        beat(4'h2, 4'h2, 4'h2, 4'h2, 1'b0);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("ign_load_count", 32'(bus.o_count), 32'd2);
        beat(4'h3, 4'h3, 4'h3, 4'h3, 1'b0);
        beat(4'h4, 4'h4, 4'h4, 4'h4, 1'b1);
        chk("ign_done", 32'(bus.o_done), 32'd1);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("ign_done_busy", 32'(bus.o_busy), 32'd0);
        step();
        chk("ign_done_ready", 32'(bus.o_ready), 32'd0);
        chk("ign_done_count", 32'(bus.o_count), 32'd4);

        // reset after five writes
        start_load();
        for (int i = 0; i < 5; i++) begin
            beat(4'hC, 4'(i), 4'(i), 4'(i), 1'b0);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(bus.o_count), 32'd0);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_rst_q", 32'(q.size()), 32'd0);
        step();
        rst = 1'b0;
        step();
        start_load();
        beat(4'hE, 4'hD, 4'hC, 4'hB, 1'b1);
        chk("post_rst_count", 32'(bus.o_count), 32'd1);
        step();
        step();
        chk("final_q_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
